// File: rtl/inv_key_expand_if.sv
// Round-key stream bundle between a controller (master) and the reverse
// AES-128 key schedule (slave).
interface inv_key_expand_if;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_last;

    modport master (
        output start, key_in, rk_ready,
        input  busy, rk_valid, rk_out, rk_round, rk_last
    );

    modport slave (
        input  start, key_in, rk_ready,
        output busy, rk_valid, rk_out, rk_round, rk_last
    );
endinterface

// File: rtl/inv_key_expand.sv
// Reverse AES-128 key schedule: loaded with the round-10 key, streams round
// keys 10 down to 0, one per accepted handshake.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] xx;
        p  = 8'h00;
        xx = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ xx;
            xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    // Multiplicative inverse as a^254 (maps 0 to 0 as the S-box requires).
    assign x2   = gf_mul(a, a);
    assign x3   = gf_mul(x2, a);
    assign x6   = gf_mul(x3, x3);
    assign x12  = gf_mul(x6, x6);
    assign x15  = gf_mul(x12, x3);
    assign x30  = gf_mul(x15, x15);
    assign x60  = gf_mul(x30, x30);
    assign x120 = gf_mul(x60, x60);
    assign x240 = gf_mul(x120, x120);
    assign x252 = gf_mul(x240, x12);
    assign inv  = gf_mul(x252, x2);

    assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module inv_key_expand #(
    parameter int NR = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    inv_key_expand_if.slave   kx
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    state_t       state_reg, state_next;
    logic [127:0] key_reg, key_next;
    logic [3:0]   round_reg, round_next;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot, sub;
    logic [7:0]   rcon;
    logic [127:0] prev_key;

    assign w0 = key_reg[31:0];
    assign w1 = key_reg[63:32];
    assign w2 = key_reg[95:64];
    assign w3 = key_reg[127:96];

    assign p3  = w3 ^ w2;
    assign p2  = w2 ^ w1;
    assign p1  = w1 ^ w0;
    assign rot = {p3[7:0], p3[31:8]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            aes_sbox u_sbox (
                .a (rot[8*gi +: 8]),
                .s (sub[8*gi +: 8])
            );
        end
    endgenerate

    always_comb begin
        rcon = 8'h00;
        case (round_reg)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign p0       = w0 ^ sub ^ {24'h000000, rcon};
    assign prev_key = {p3, p2, p1, p0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            key_reg   <= '0;
            round_reg <= '0;
        end else begin
            state_reg <= state_next;
            key_reg   <= key_next;
            round_reg <= round_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        key_next   = key_reg;
        round_next = round_reg;
        case (state_reg)
            IDLE: begin
                if (kx.start) begin
                    key_next   = kx.key_in;
                    round_next = LAST_ROUND;
                    state_next = RUN;
                end
            end
            RUN: begin
                // start is deliberately ignored here, even on the final handshake.
                if (kx.rk_ready) begin
                    if (round_reg == 4'd0) begin
                        state_next = IDLE;
                    end else begin
                        key_next   = prev_key;
                        round_next = round_reg - 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign kx.busy     = (state_reg == RUN);
    assign kx.rk_valid = (state_reg == RUN);
    assign kx.rk_out   = key_reg;
    assign kx.rk_round = round_reg;
    assign kx.rk_last  = (state_reg == RUN) && (round_reg == 4'd0);
endmodule

// File: tb/tb_inv_key_expand.sv
// Bench for the reverse AES-128 key schedule: forward-expansion reference
// model, scoreboard queue and a negedge monitor.
module tb_inv_key_expand;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inv_key_expand_if kx ();

    inv_key_expand #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kx    (kx)
    );

    typedef struct {
        logic [127:0] key;
        logic [3:0]   round;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    bit           ready_rand = 0;
    logic [7:0]   sbox_t  [0:255];
    logic [7:0]   exp_tab [0:255];
    int           log_tab [0:255];
    logic [127:0] rk_model [0:10];
    logic [127:0] got [0:10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] bswap(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = v[127-8*i -: 8];
        return r;
    endfunction

    // S-box from log/antilog tables over generator 3, then the affine map.
    task automatic build_sbox();
        logic [7:0] p, b, s;
        logic [7:0] c;
        c = 8'h63;
        p = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_tab[i] = p;
            log_tab[p] = i;
            p = p ^ xtime(p);
        end
        for (int a = 0; a < 256; a++) begin
            b = (a == 0) ? 8'h00 : exp_tab[(255 - log_tab[a]) % 255];
            for (int i = 0; i < 8; i++)
                s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
            sbox_t[a] = s;
        end
    endtask

    task automatic expand(input logic [127:0] ck);
        logic [7:0] kb [0:175];
        logic [7:0] t  [0:3];
        logic [7:0] rc, tmp;
        rc = 8'h01;
        for (int k = 0; k < 16; k++) kb[k] = ck[8*k +: 8];
        for (int i = 4; i < 44; i++) begin
            for (int b = 0; b < 4; b++) t[b] = kb[4*(i-1)+b];
            if (i % 4 == 0) begin
                tmp  = t[0];
                t[0] = sbox_t[t[1]] ^ rc;
                t[1] = sbox_t[t[2]];
                t[2] = sbox_t[t[3]];
                t[3] = sbox_t[tmp];
                rc   = xtime(rc);
            end
            for (int b = 0; b < 4; b++) kb[4*i+b] = kb[4*(i-4)+b] ^ t[b];
        end
        for (int r = 0; r <= 10; r++)
            for (int k = 0; k < 16; k++) rk_model[r][8*k +: 8] = kb[16*r+k];
    endtask

    // Consumer-side ready: always 1, or random when ready_rand is set.
    initial begin
        kx.rk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            kx.rk_ready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor: pops expectations on every handshake, checks stalls hold stable.
    initial begin
        logic         last_valid, last_ready;
        logic [127:0] last_out;
        logic [3:0]   last_round;
        exp_t         e;
        last_valid = 1'b0;
        last_ready = 1'b0;
        last_out   = '0;
        last_round = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_valid = 1'b0;
            end else begin
                if (last_valid && !last_ready) begin
                    chk("stall_valid", 128'(kx.rk_valid), 128'(1));
                    chk("stall_out", kx.rk_out, last_out);
                    chk("stall_round", 128'(kx.rk_round), 128'(last_round));
                end
                if (sb.size() == 0) begin
                    chk("spurious_valid", 128'(kx.rk_valid), 128'(0));
                end else if (kx.rk_valid && kx.rk_ready) begin
                    e = sb.pop_front();
                    $display("rk round %0d key %h last %0d", kx.rk_round, kx.rk_out, kx.rk_last);
                    chk("rk_out", kx.rk_out, e.key);
                    chk("rk_round", 128'(kx.rk_round), 128'(e.round));
                    chk("rk_last", 128'(kx.rk_last), 128'(e.round == 4'd0));
                    if (kx.rk_round <= 4'd10) got[kx.rk_round] = kx.rk_out;
                end
                last_valid = kx.rk_valid;
                last_ready = kx.rk_ready;
                last_out   = kx.rk_out;
                last_round = kx.rk_round;
            end
        end
    end

    // Entered and left at posedge+1. stop5 abandons the run at round 5.
    task automatic run_key(input logic [127:0] ck, input bit spam, input bit stop5);
        int   cyc;
        exp_t e;
        expand(ck);
        chk("idle_before_start", 128'(kx.busy), 128'(0));
        for (int r = 10; r >= 0; r--) begin
            e.key   = rk_model[r];
            e.round = 4'(r);
            sb.push_back(e);
        end
        kx.start  = 1'b1;
        kx.key_in = rk_model[10];
        @(posedge clk);
        #1;
        kx.start  = 1'b0;
        kx.key_in = {$urandom, $urandom, $urandom, $urandom};
        chk("first_latency", 128'(kx.rk_valid), 128'(1));
        chk("first_round", 128'(kx.rk_round), 128'(10));
        cyc = 0;
        while (sb.size() != 0 && cyc < 300) begin
            if (stop5 && kx.rk_valid && kx.rk_round == 4'd5) break;
            if (spam) begin
                kx.start  = 1'b1;
                kx.key_in = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        kx.start = 1'b0;
        if (stop5) begin
            chk("reached_round5", 128'(kx.rk_round), 128'(5));
        end else begin
            chk("seq_complete", 128'(sb.size()), 128'(0));
            chk("busy_after_last", 128'(kx.busy), 128'(0));
            chk("valid_after_last", 128'(kx.rk_valid), 128'(0));
        end
    endtask

    initial begin
        logic [127:0] fips_ck, rnd_ck;
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] fips_ck, rnd_ck;
        build_sbox();
        fips_ck   = bswap(128'h2b7e151628aed2a6abf7158809cf4f3c);
        rst_n     = 1'b0;
        kx.start  = 1'b0;
        kx.key_in = '0;
        #1;
        chk("reset_valid", 128'(kx.rk_valid), 128'(0));
        chk("reset_busy", 128'(kx.busy), 128'(0));
        chk("reset_last", 128'(kx.rk_last), 128'(0));
        chk("reset_round", 128'(kx.rk_round), 128'(0));
        chk("reset_out", kx.rk_out, 128'(0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 vector with continuous ready.
        ready_rand = 0;
        run_key(fips_ck, 0, 0);
        chk("fips_r10", got[10], bswap(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        chk("fips_r9",  got[9],  bswap(128'hac7766f319fadc2128d12941575c006e));
        chk("fips_r1",  got[1],  bswap(128'ha0fafe1788542cb123a339392a6c7605));
        chk("fips_r0",  got[0],  bswap(128'h2b7e151628aed2a6abf7158809cf4f3c));

        // Same key under random backpressure, then with start spam.
        @(posedge clk);
        #1;
        ready_rand = 1;
        run_key(fips_ck, 0, 0);
        chk("stall_fips_r9", got[9], bswap(128'hac7766f319fadc2128d12941575c006e));
        @(posedge clk);
        #1;
        run_key(fips_ck, 1, 0);
        chk("spam_fips_r0", got[0], bswap(128'h2b7e151628aed2a6abf7158809cf4f3c));

        // Reset in the middle of the stream.
        @(posedge clk);
        #1;
        ready_rand = 0;
        run_key(fips_ck, 0, 1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midreset_valid", 128'(kx.rk_valid), 128'(0));
        chk("midreset_busy", 128'(kx.busy), 128'(0));
        chk("midreset_round", 128'(kx.rk_round), 128'(0));
        chk("midreset_out", kx.rk_out, 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("valid_after_reset", 128'(kx.rk_valid), 128'(0));
        end
        run_key(fips_ck, 0, 0);
        chk("rerun_r10", got[10], bswap(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

        // All-zero cipher key: round-0 output must be zero.
        @(posedge clk);
        #1;
        run_key(128'h0, 0, 0);
        chk("zero_key_r0", got[0], 128'h0);

        // Random keys issued back to back in the first IDLE cycle.
        for (int n = 0; n < 8; n++) begin
            ready_rand = n[0];
            rnd_ck = {$urandom, $urandom, $urandom, $urandom};
            run_key(rnd_ck, n[1], 0);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inv_key_expand.md
Name: inv_key_expand

Overview:
- Reverse (decryption-direction) AES-128 key schedule. Loaded with the final round key (round 10), it regenerates round keys 10, 9, ... 0 one per cycle, running the key expansion backwards with the round constants in descending order.
- Sits in front of the inverse cipher datapath so decryption needs no stored 176-byte schedule.
- Output is a valid/ready stream so the inverse-round pipeline can stall it.

Parameters:
- NR, 10, number of AES rounds; only 10 (AES-128) is supported. The round counter is 4 bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  load request; honoured only in IDLE
- key_in  input  128  round-10 key, sampled when start is accepted
- busy  output  1  high whenever state != IDLE
- rk_valid  output  1  round key on rk_out is valid
- rk_ready  input  1  consumer accepts rk_out
- rk_out  output  128  current round key
- rk_round  output  4  round index of rk_out (10 down to 0)
- rk_last  output  1  high with the round-0 key

Behaviour:
- Packing:
  - Key bytes b0..b15 are packed with b0 at [7:0] and b15 at [127:120].
  - Word wj = key[32j+31:32j], with byte 0 of each word at [7:0]. This matches the codebase rcon placement, so Rcon(r) occupies bits [7:0].
- Reset, asynchronous on rst_n low: state=IDLE, rk_valid=0, busy=0, rk_last=0, rk_round=0, rk_out=0. Takes effect mid-stream; any in-progress sequence is abandoned with no further output.
- States:
  - IDLE:
    - start=1 -> key_reg<=key_in, round<=10, go to RUN.
    - rk_valid rises the following cycle, so start-to-first-valid latency is 1 cycle.
  - RUN:
    - rk_valid=1, rk_out=key_reg, rk_round=round, rk_last=(round==0).
    - On rk_valid&rk_ready with round!=0: key_reg<=prev(key_reg, round), round<=round-1, stay in RUN. Throughput is 1 key/cycle under continuous ready.
    - On rk_valid&rk_ready with round==0: go to IDLE; rk_valid drops the next cycle.
    - With rk_ready=0: rk_out, rk_round and rk_valid hold stable.
- prev(K, r), with K words w0..w3:
  - p3=w3^w2, p2=w2^w1, p1=w1^w0.
  - p0=w0^SubWord(RotWord(p3))^Rcon(r).
  - RotWord(x)={x[7:0],x[31:8]}, i.e. byte0<-byte1, byte1<-byte2, byte2<-byte3, byte3<-byte0.
  - SubWord applies the forward AES S-box to each byte, using 4 instances of the team's forward S-box component.
  - Rcon(r) for r=1..10 is 01,02,04,08,10,20,40,80,1b,36 in byte 0; all other bytes are 0.
  - prev is purely combinational from key_reg, with one register stage per round.
- start while busy is ignored. No restart is permitted without reset or a return to IDLE.
- start in the same cycle the round-0 key is accepted is ignored, because state is still RUN. The new start must be issued in IDLE.
- No key_in storage happens outside start acceptance.

Test Plan:
- Reset, then start with key_in = FIPS-197 round-10 key d014f9a8c9ee2589e13f0cc8b6630ca6 (byte string), rk_ready=1 -> 11 consecutive valids:
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - round 9 = ac7766f319fadc2128d12941575c006e
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c, with rk_last=1
  - busy=0 one cycle after the final handshake.
- Same stimulus with rk_ready toggled pseudo-randomly -> identical key sequence; rk_out and rk_round stable during every stall; no key skipped or duplicated.
- start pulsed repeatedly during RUN with a different key_in -> ignored; sequence unchanged.
- rst_n asserted during round 5 -> outputs zero immediately. After release, rk_valid stays 0 until a new start. A fresh start of the same key reproduces the full sequence from round 10.
- Key all-zero expanded forward in the model, last key fed in -> round 0 output = 128'h0. Random-key regression against a software forward expansion: every rk_round key matches.
- Back-to-back sequences: start asserted in the first IDLE cycle after completion -> the new sequence begins with a 1-cycle latency and no corruption from the previous key_reg.
